sc_decoder: RTL
===============

SC_DECODER -- requirements
Module: sc_decoder

Interface
REQ-001 The module SHALL have parameter WINDOW_LOG2, default 8, giving log2 of the window length N = 2^WINDOW_LOG2 bits (legal range 1..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port start, input, 1 bit: single-cycle pulse that clears the counters and opens a new window.
REQ-005 The module SHALL have port cont, input, 1 bit: when high at window end, the next window opens automatically.
REQ-006 The module SHALL have port bit_in, input, 1 bit: stochastic bitstream sample.
REQ-007 The module SHALL have port bit_valid, input, 1 bit: bit_in is consumed on every cycle where bit_valid is high in ACCUM.
REQ-008 The module SHALL have port out_data, output, WINDOW_LOG2+2 bits: decoded value of the last completed window.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data holds an unconsumed result.
REQ-010 The module SHALL have port out_ready, input, 1 bit: sink accepts out_data when out_valid and out_ready are both high.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in ACCUM.
REQ-012 The module SHALL have port overrun, output, 1 bit: sticky flag, a completed window's result was dropped.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM. IDLE->ACCUM on start. ACCUM->ACCUM on start (partial window discarded, counters cleared). At window end: ACCUM if cont=1, else IDLE.
REQ-014 In ACCUM, each accepted bit SHALL increment sample_cnt (WINDOW_LOG2+1 bits) and add bit_in to ones_cnt (WINDOW_LOG2+1 bits); no increment occurs when bit_valid=0.
REQ-015 Window end SHALL be the edge that accepts the Nth bit; out_valid SHALL be high from the following cycle (latency 1), and counters SHALL be zero in that cycle.
REQ-016 Unipolar result SHALL be ones_cnt zero-extended to WINDOW_LOG2+2 bits (range 0..N).
REQ-017 Output SHALL be a single-entry register: out_data is stable while out_valid=1 and out_ready=0; out_valid clears on the handshake edge.
REQ-018 If window end coincides with a handshake on the same edge, the new result SHALL be loaded and out_valid stays high.
REQ-019 If window end occurs while out_valid=1 and out_ready=0, the new result SHALL be discarded, out_data retained, overrun set.
REQ-020 overrun SHALL clear only on rst or start.
REQ-021 start in IDLE or ACCUM SHALL NOT affect out_data/out_valid.
REQ-022 bit_valid and bit_in SHALL be ignored in IDLE; start with bit_valid on the same edge does not count that bit.

Reset
REQ-023 On rst high at a clock edge: state=IDLE, sample_cnt=0, ones_cnt=0, out_data=0, out_valid=0, busy=0, overrun=0; rst overrides start, bit_valid and handshakes, including mid-window.

Configuration
REQ-024 Macro SC_DECODER_BIPOLAR_EN SHALL, when defined, make out_data the two's-complement value 2*ones_cnt - N (range -N..+N, WINDOW_LOG2+2 bits signed).
REQ-025 Without SC_DECODER_BIPOLAR_EN, out_data SHALL be the unipolar value of REQ-016; all timing and handshake behaviour is identical in both builds.

Verification (WINDOW_LOG2=4, N=16)
REQ-026 rst, start, 16 valid bits with 5 ones, out_ready=1 -> out_valid one cycle after 16th bit, out_data=5 (bipolar build: -6).
REQ-027 start, 16 bits all ones with bit_valid toggling every other cycle -> out_data=16 after 32 cycles; bipolar build +16.
REQ-028 cont=1, out_ready=0, two consecutive windows (3 ones, then 9 ones) -> out_data stays 3, overrun=1 after the second window end; start clears overrun.
REQ-029 start after 10 bits of a window, then 16 bits with 7 ones -> out_data=7, the first 10 bits ignored.
REQ-030 rst asserted mid-window with out_valid=1 -> all outputs 0 next cycle; subsequent bit_valid without start produces no result.
REQ-031 cont=1, out_ready asserted on the same edge as the second window end -> first result consumed, second loaded, out_valid stays 1, overrun=0.

Source files
------------

// File: rtl/sc_decoder.sv
// sc_decoder -- stochastic bitstream decoder.
//
// Counts the ones in a window of N = 2**WINDOW_LOG2 accepted bits and
// presents the count as a result in a single-entry output register that
// uses a valid/ready handshake.
//
// Build option: define SC_DECODER_BIPOLAR_EN to make out_data carry the
// bipolar value 2*ones - N (two's complement). When it is not defined,
// out_data carries the unipolar value, which is the ones count itself.
// Both builds have the same timing and handshake behaviour.
//
// Ports:
//   clk        in   single clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   one-cycle pulse: clear the counters and open a new window
//   cont       in   at window end, open the next window automatically
//   bit_in     in   stochastic bitstream sample
//   bit_valid  in   bit_in is consumed on this cycle (ACCUM only)
//   out_data   out  decoded value of the last completed window (WINDOW_LOG2+2 bits)
//   out_valid  out  out_data holds a result that has not been consumed
//   out_ready  in   sink accepts out_data when out_valid is also high
//   busy       out  high while a window is open (ACCUM)
//   overrun    out  sticky: a completed result was dropped (cleared by rst/start)
module sc_decoder #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   cont,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [WINDOW_LOG2+1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overrun
);

  localparam int W = WINDOW_LOG2;

  // Count value held just before the Nth bit is accepted.
  localparam logic [W:0]   LAST_CNT = {1'b0, {W{1'b1}}};
  // N expressed at output width, used by the bipolar conversion.
  localparam logic [W+1:0] N_EXT    = {2'b01, {W{1'b0}}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_next_s;
  logic [W:0]   sample_cnt_r;
  logic [W:0]   ones_cnt_r;
  logic [W:0]   ones_next_s;
  logic         accept_s;
  logic         win_end_s;
  logic         handshake_s;
  logic         load_s;
  logic         drop_s;
  logic [W+1:0] out_data_r;
  logic         out_valid_r;
  logic         overrun_r;

  // Maps a completed window's ones count to the output encoding.
  function automatic logic [W+1:0] decode_value(input logic [W:0] ones);
`ifdef SC_DECODER_BIPOLAR_EN
    decode_value = {ones, 1'b0} - N_EXT;
`else
    decode_value = {1'b0, ones};
`endif
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic. start takes priority over the bit on the same edge.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = ACCUM;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (start) begin
          state_next_s = ACCUM;
        end else if (win_end_s) begin
          state_next_s = cont ? ACCUM : IDLE;
        end else begin
          state_next_s = ACCUM;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Control decode: bit acceptance, window end and output register actions.
  always_comb begin
    accept_s    = (state_r == ACCUM) && !start && bit_valid;
    win_end_s   = accept_s && (sample_cnt_r == LAST_CNT);
    ones_next_s = ones_cnt_r + {{W{1'b0}}, bit_in};
    handshake_s = out_valid_r && out_ready;
    // A handshake on the window-end edge frees the register for the new result.
    load_s      = win_end_s && (!out_valid_r || out_ready);
    drop_s      = win_end_s && out_valid_r && !out_ready;
  end

  // Window counters; they read zero in the cycle after window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_r <= {(W+1){1'b0}};
      ones_cnt_r   <= {(W+1){1'b0}};
    end else if (start || win_end_s) begin
      sample_cnt_r <= {(W+1){1'b0}};
      ones_cnt_r   <= {(W+1){1'b0}};
    end else if (accept_s) begin
      sample_cnt_r <= sample_cnt_r + {{W{1'b0}}, 1'b1};
      ones_cnt_r   <= ones_next_s;
    end else begin
      sample_cnt_r <= sample_cnt_r;
      ones_cnt_r   <= ones_cnt_r;
    end
  end

  // Single-entry result register with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {(W+2){1'b0}};
      out_valid_r <= 1'b0;
    end else if (load_s) begin
      out_data_r  <= decode_value(ones_next_s);
      out_valid_r <= 1'b1;
    end else if (handshake_s) begin
      out_data_r  <= out_data_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky overrun flag; only rst or start clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (start) begin
      overrun_r <= 1'b0;
    end else if (drop_s) begin
      overrun_r <= 1'b1;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  // Output drive; every output comes straight from a register.
  always_comb begin
    out_data  = out_data_r;
    out_valid = out_valid_r;
    overrun   = overrun_r;
    busy      = (state_r == ACCUM);
  end

endmodule
